// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO with occupancy flags, over/underflow pulses
// and a selectable registered or first-word-fall-through read port.
module param_sync_fifo #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned FWFT      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // Flags come from the registered count only, so no input-to-flag path exists.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == CW'(0));
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage is intentionally not reset; empty/rd_valid mask stale words.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; a pop simply advances rd_ptr.
            assign rd_data  = empty ? '0 : mem[rd_ptr];
            assign rd_valid = !empty;
        end else begin : g_reg
            logic [DATA_W-1:0] rd_q;
            logic              rd_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q       <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_q <= mem[rd_ptr];
                    end
                end
            end

            assign rd_data  = rd_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule
